vs_latch_bank_arbiter: RTL



---
 rtl/vs_latch_bank_arbiter_pkg.sv | 37 +++
 rtl/vs_latch_bank_arbiter_if.sv | 25 ++
 rtl/vs_d_latch.sv | 17 +
 rtl/vs_latch_bank_arbiter_rr_arbiter.sv | 27 ++
 rtl/vs_latch_bank_arbiter.sv | 111 +++++++++++
 5 files changed

// File: rtl/vs_latch_bank_arbiter_pkg.sv
// Shared types and helpers for the latch-bank write arbiter.
//   lat_state_e : write sequencer states (IDLE -> SETUP -> OPEN -> HOLD)
//   rr_pick()   : index of the first set request bit at or above a pointer,
//                 wrapping modulo n. Callers zero-extend req to RR_MAX bits.
package vs_latch_pkg;

  localparam int RR_MAX = 32;
  localparam int RR_IW  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } lat_state_e;

  // Scan offsets 0..n-1 from ptr; the first hit wins. Returns ptr when no
  // bit is set, which callers mask with their own valid flag.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      if (!found && i < n) begin
        idx = (ptr + i) % n;
        if (req[idx[RR_IW-1:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/vs_latch_bank_arbiter_if.sv
// Requester / latch-bank bus of the latch-bank arbiter.
//   master : requesting logic (drives req/req_addr/req_data, sees the rest)
//   slave  : the arbiter (drives gnt, busy, lat_d, lat_en)
// req_addr/req_data are packed per requester; requester i occupies
// bits [i*W +: W] of the flattened vector.
interface vs_latch_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
);
  localparam int NWORDS = 1 << ADDR_W;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             gnt;
  logic                           busy;
  logic [DATA_W-1:0]              lat_d;
  logic [NWORDS-1:0]              lat_en;

  modport master (output req, req_addr, req_data,
                  input  gnt, busy, lat_d, lat_en);
  modport slave  (input  req, req_addr, req_data,
                  output gnt, busy, lat_d, lat_en);
endinterface

// File: rtl/vs_d_latch.sv
// Transparent-high D latch, one word of the shared bank.
//   en : transparent while high
//   d  : data in (shared bus)
//   q  : stored word
module vs_d_latch #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_latch begin
    if (en) q <= d;
  end

endmodule

// File: rtl/vs_latch_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot winner (zero when no request)
//   valid : any request present
module vs_rr_arbiter
  import vs_latch_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  int unsigned idx;

  always_comb begin
    valid = |req;
    idx   = rr_pick(RR_MAX'(req), 32'(ptr), NUM_REQ);
    grant = '0;
    if (valid) grant = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/vs_latch_bank_arbiter.sv
// Round-robin write arbiter for a bank of 2**ADDR_W D latches.
// Each write runs SETUP (data on bus, enables low) -> OPEN (one enable high
// for OPEN_CYCLES) -> HOLD (enables low, data still held, gnt pulse), so a
// latch enable never overlaps a change of lat_d. Every output is a flop.
//   gclk   : clock, rising edge
//   grst_n : asynchronous active-low reset
//   bus    : slave side of vs_latch_bank_arbiter_if
module vs_latch_bank_arbiter
  import vs_latch_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int OPEN_CYCLES = 1
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  vs_latch_bank_arbiter_if.slave    bus
);

  localparam int NWORDS = 1 << ADDR_W;
  localparam int PTR_W  = $clog2(NUM_REQ);
  // Counter holds OPEN_CYCLES-1 down to 0.
  localparam int CNT_W  = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  lat_state_e         state;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  lat_d_q;
  logic [NWORDS-1:0]  lat_en_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_nxt;

  vs_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (arb_gnt),
    .valid (arb_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_gnt[i]) win_idx = PTR_W'(i);
  end

  assign ptr_nxt = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  // lat_d_q doubles as the captured data register: it is loaded on capture
  // and only changes again at the next capture, which keeps it frozen from
  // SETUP through HOLD and parked on the last value while idle.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state    <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            win_q   <= win_idx;
            addr_q  <= bus.req_addr[win_idx];
            lat_d_q <= bus.req_data[win_idx];
            busy_q  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          lat_en_q <= NWORDS'(1) << addr_q;
          cnt_q    <= CNT_W'(OPEN_CYCLES - 1);
          state    <= OPEN;
        end
        OPEN: begin
          if (cnt_q == '0) begin
            lat_en_q <= '0;
            gnt_q    <= NUM_REQ'(1) << win_q;
            state    <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          ptr_q  <= ptr_nxt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lat_d  = lat_d_q;
  assign bus.lat_en = lat_en_q;
  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_q;

endmodule
